tmds_channel_rx: RTL

Receive-side counterpart of `tmds_channel` for one HDMI TMDS lane. It accepts 10-bit raw words from an external deserializer, one word per `clk_pixel` cycle. It finds the 10-bit word boundary by bit-slipping until control tokens appear reliably, then decodes every aligned word in parallel as video, control, TERC4 and guard-band symbols. Three instances (CN = 0, 1, 2) sit behind the deserializers in the HDMI sink path and feed the downstream period/packet recovery logic.

---
 rtl/hdmi_pkg.sv | 29 ++
 rtl/tmds_decode.sv | 38 +++
 rtl/tmds_channel_rx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI TMDS definitions: control tokens, TERC4 table, guard-band codes
// and the receive alignment state type.
package hdmi_pkg;

    localparam logic [9:0] CTRL_TOKEN [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Lane 0 carries no island guard; its entry is never matched.
    localparam logic [9:0] VIDEO_GUARD  [3] = '{10'b1011001100, 10'b0100110011, 10'b1011001100};
    localparam logic [9:0] ISLAND_GUARD [3] = '{10'b0000000000, 10'b0100110011, 10'b0100110011};

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } rx_state_e;

    function automatic logic [3:0] next_offset(input logic [3:0] cur);
        return (cur == 4'd9) ? 4'd0 : cur + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_decode.sv
// Combinational TMDS symbol decoder: video 8b/10b, control token and TERC4 lookups.
module tmds_decode
    import hdmi_pkg::*;
(
    input  logic [9:0] word,
    output logic [7:0] video_data,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       terc4_valid,
    output logic [3:0] terc4
);

    logic [7:0] d;

    assign d = word[9] ? ~word[7:0] : word[7:0];
    // q[8] selects XOR (1) or XNOR (0) chaining of adjacent bits
    assign video_data = {(d[7:1] ^ d[6:0]) ^ {7{~word[8]}}, d[0]};

    always_comb begin
        ctrl_valid  = 1'b0;
        ctrl        = 2'd0;
        terc4_valid = 1'b0;
        terc4       = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (word == CTRL_TOKEN[i]) begin
                ctrl_valid = 1'b1;
                ctrl       = 2'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (word == TERC4_CODE[i]) begin
                terc4_valid = 1'b1;
                terc4       = 4'(i);
            end
        end
    end

endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS receive lane: bit-slip word alignment on control tokens, then a
// registered parallel decode of every aligned word.
module tmds_channel_rx
    import hdmi_pkg::*;
#(
    parameter int CN            = 0,
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] raw,
    output logic       locked,
    output logic [3:0] offset,
    output logic [7:0] video_data,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       terc4_valid,
    output logic [3:0] terc4,
    output logic       video_guard,
    output logic       island_guard
);

    localparam int              CW       = $clog2(SEARCH_WINDOW + 1);
    localparam logic [CW-1:0]   WIN_LAST = CW'(SEARCH_WINDOW - 1);
    localparam logic [CW-1:0]   RUN_LOCK = CW'(LOCK_COUNT);

    logic [9:0]    prev;
    logic [9:0]    word;
    logic [31:0]   window;
    logic [9:0]    aligned;

    logic [7:0]    dec_video;
    logic          dec_ctrl_valid;
    logic [1:0]    dec_ctrl;
    logic          dec_terc4_valid;
    logic [3:0]    dec_terc4;

    rx_state_e     state, state_next;
    logic [3:0]    offset_next;
    logic [CW-1:0] run, run_next;
    logic [CW-1:0] win, win_next;
    logic [CW-1:0] run_inc;

    // Padding keeps the variable part-select in range for any 4-bit offset.
    assign window  = {12'd0, raw, prev};
    assign aligned = window[offset +: 10];

    tmds_decode u_decode (
        .word        (word),
        .video_data  (dec_video),
        .ctrl_valid  (dec_ctrl_valid),
        .ctrl        (dec_ctrl),
        .terc4_valid (dec_terc4_valid),
        .terc4       (dec_terc4)
    );

    // Stage 1: history + aligned word; stage 2: registered decode outputs
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            prev         <= '0;
            word         <= '0;
            video_data   <= '0;
            ctrl_valid   <= 1'b0;
            ctrl         <= '0;
            terc4_valid  <= 1'b0;
            terc4        <= '0;
            video_guard  <= 1'b0;
            island_guard <= 1'b0;
        end else begin
            prev         <= raw;
            word         <= aligned;
            video_data   <= dec_video;
            ctrl_valid   <= dec_ctrl_valid;
            ctrl         <= dec_ctrl;
            terc4_valid  <= dec_terc4_valid;
            terc4        <= dec_terc4;
            video_guard  <= (word == VIDEO_GUARD[CN]);
            island_guard <= (CN != 0) && (word == ISLAND_GUARD[CN]);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state  <= SEARCH;
            offset <= '0;
            run    <= '0;
            win    <= '0;
        end else begin
            state  <= state_next;
            offset <= offset_next;
            run    <= run_next;
            win    <= win_next;
        end
    end

    // The FSM watches the registered ctrl_valid, i.e. tokens as seen on the outputs.
    assign run_inc = (run == RUN_LOCK) ? run : run + CW'(1);

    always_comb begin
        state_next  = state;
        offset_next = offset;
        run_next    = ctrl_valid ? run_inc : '0;
        win_next    = win + CW'(1);
        case (state)
            SEARCH: begin
                if (run_next == RUN_LOCK) begin
                    state_next = LOCKED;
                    win_next   = '0;
                end else if (win == WIN_LAST) begin
                    offset_next = next_offset(offset);
                    run_next    = '0;
                    win_next    = '0;
                end
            end
            LOCKED: begin
                if (ctrl_valid) begin
                    win_next = '0;
                end
                if (win == WIN_LAST) begin
                    state_next  = SEARCH;
                    offset_next = next_offset(offset);
                    run_next    = '0;
                    win_next    = '0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

endmodule
